// File: rtl/inpass4_sync_filter.sv
// Four-channel pad-to-fabric input BEL: per-channel pass, register, 2-flop sync or sync+debounce.
// Latency: mode 00 combinational, 01 one edge, 10 two edges, 11 FILTER_CYCLES+2 edges.
// Backpressure: none; every stage advances on every UserCLK edge.
module inpass4_sync_filter #(
    parameter int NoConfigBits  = 8,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                    UserCLK,
    input  logic                    RESET,
    input  logic                    I0,
    input  logic                    I1,
    input  logic                    I2,
    input  logic                    I3,
    output logic                    O0,
    output logic                    O1,
    output logic                    O2,
    output logic                    O3,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    // Counter is wide enough to hold FILTER_CYCLES-1 and is compared against
    // exactly that value, so it can never wrap.
    localparam int              CntW   = $clog2(FILTER_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

    localparam logic [1:0] ModePass = 2'b00;
    localparam logic [1:0] ModeReg  = 2'b01;
    localparam logic [1:0] ModeSync = 2'b10;
    localparam logic [1:0] ModeFilt = 2'b11;

    logic [3:0]      padIn;
    logic [3:0]      fabricOut;

    // Per-channel pipeline state. Bit n of each vector belongs to channel n.
    // s1 is the only flop that may see an asynchronous pad; q (mode 01) and the
    // pass path (mode 00) assume the pad is already synchronous to UserCLK.
    logic [3:0]      q;
    logic [3:0]      s1;
    logic [3:0]      s2;
    logic [3:0]      f;
    logic [3:0]      fNext;
    logic [CntW-1:0] cnt     [4];
    logic [CntW-1:0] cntNext [4];
    logic [1:0]      mode    [4];

    assign padIn = {I3, I2, I1, I0};
    assign O0    = fabricOut[0];
    assign O1    = fabricOut[1];
    assign O2    = fabricOut[2];
    assign O3    = fabricOut[3];

    // Split the frame config into one 2-bit mode field per channel.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            mode[n] = ConfigBits[2*n +: 2];
        end
    end

    // Debounce rule: a synchronized level that differs from the filtered level
    // must persist for FILTER_CYCLES consecutive edges before it is adopted;
    // any return to agreement discards the partial count.
    always_comb begin
        fNext = f;
        for (int n = 0; n < 4; n++) begin
            cntNext[n] = cnt[n];
            if (s2[n] == f[n]) begin
                cntNext[n] = '0;
            end else if (cnt[n] == CntMax) begin
                fNext[n]   = s2[n];
                cntNext[n] = '0;
            end else begin
                cntNext[n] = cnt[n] + CntW'(1);
            end
        end
    end

    // All stages run every cycle irrespective of mode, so a mode switch only
    // changes which stage is observed; reset clears every stage and takes
    // priority over all updates.
    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            q  <= '0;
            s1 <= '0;
            s2 <= '0;
            f  <= '0;
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= '0;
            end
        end else begin
            q  <= padIn;
            s1 <= padIn;
            s2 <= s1;
            f  <= fNext;
            for (int n = 0; n < 4; n++) begin
                cnt[n] <= cntNext[n];
            end
        end
    end

    // Output select: purely combinational on the mode bits so a reconfigured
    // channel immediately shows the selected stage's current value.
    always_comb begin
        fabricOut = '0;
        for (int n = 0; n < 4; n++) begin
            case (mode[n])
                ModePass: fabricOut[n] = padIn[n];
                ModeReg:  fabricOut[n] = q[n];
                ModeSync: fabricOut[n] = s2[n];
                ModeFilt: fabricOut[n] = f[n];
                default:  fabricOut[n] = 1'b0;
            endcase
        end
    end

endmodule
